// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports,
// same-cycle write bypass and a sequenced bulk-clear engine.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          re,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  logic              wr0_ok;
  logic              wr1_ok;

  assign busy = (state_q == CLEAR);
  assign done = done_q;

  // Port 1 owns a colliding address; port 0 is dropped outright.
  assign wr1_ok = we1 && (waddr1 != '0) && !busy;
  assign wr0_ok = we0 && (waddr0 != '0) && !busy &&
                  !(we1 && (waddr1 == waddr0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= ONE;
            done_q  <= (ONE == LAST);
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + ONE;
            done_q <= ((cnt_q + ONE) == LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (busy)   mem_q[cnt_q]  <= '0;
      if (wr0_ok) mem_q[waddr0] <= wdata0;
      if (wr1_ok) mem_q[waddr1] <= wdata1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra    = '0;
    rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      if (re[k] && rst && !busy && (ra != '0)) begin
        if (we1 && (waddr1 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata1;
        end else if (we0 && (waddr0 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata0;
        end else begin
          rdata[k*DATA_W +: DATA_W] = mem_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default configuration plus a
// 16-bit / 8-entry / 4-read-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        clr_req, busy, done;

  logic [3:0]  re_b;
  logic [11:0] raddr_b;
  logic [63:0] rdata_b;
  logic        we0_b, we1_b;
  logic [2:0]  waddr0_b, waddr1_b;
  logic [15:0] wdata0_b, wdata1_b;
  logic        clr_req_b, busy_b, done_b;

  int vecs = 0;
  int errs = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .clk(clk), .rst(rst),
    .re(re), .raddr(raddr), .rdata(rdata),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .clr_req(clr_req), .busy(busy), .done(done)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4)) dut_b (
    .clk(clk), .rst(rst),
    .re(re_b), .raddr(raddr_b), .rdata(rdata_b),
    .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
    .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
    .clr_req(clr_req_b), .busy(busy_b), .done(done_b)
  );

  task automatic test_reset();
    rst = 1'b0;
    re = 2'b11; raddr = {5'd5, 5'd7};
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0;
    wdata0 = 0; wdata1 = 0; clr_req = 0;
    re_b = 4'hf; raddr_b = 0;
    we0_b = 0; we1_b = 0; waddr0_b = 0; waddr1_b = 0;
    wdata0_b = 0; wdata1_b = 0; clr_req_b = 0;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (rdata !== 64'h0) begin
      errs++; $display("FAIL reset_hold_rdata got=%h exp=0", rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done);
    end
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      vecs++;
      if (rdata !== 64'h0) begin
        errs++; $display("FAIL reset_zero addr=%0d got=%h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'h12345678;
    @(negedge clk);
    we0 = 0; we1 = 0;
    re = 2'b11; raddr = {5'd0, 5'd5};
    #1;
    vecs++;
    if (rdata[31:0] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL basic_rd5 got=%h exp=deadbeef", rdata[31:0]);
    end
    vecs++;
    if (rdata[63:32] !== 32'h0) begin
      errs++; $display("FAIL basic_reg0 got=%h exp=0", rdata[63:32]);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33333333;
    @(negedge clk);
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    re = 2'b11; raddr = {5'd3, 5'd7};
    #1;
    vecs++;
    if (rdata[31:0] !== 32'h22222222) begin
      errs++; $display("FAIL coll_bypass got=%h exp=22222222", rdata[31:0]);
    end
    vecs++;
    if (rdata[63:32] !== 32'h33333333) begin
      errs++; $display("FAIL coll_indep got=%h exp=33333333", rdata[63:32]);
    end
    @(negedge clk);
    we0 = 0; we1 = 0;
    #1;
    vecs++;
    if (rdata[31:0] !== 32'h22222222) begin
      errs++; $display("FAIL coll_stored got=%h exp=22222222", rdata[31:0]);
    end
    we0 = 1; waddr0 = 5'd10; wdata0 = 32'hA0A0A0A0;
    re = 2'b01; raddr = {5'd7, 5'd10};
    #1;
    vecs++;
    if (rdata !== 64'h00000000_A0A0A0A0) begin
      errs++; $display("FAIL bypass0_re got=%h exp=00000000a0a0a0a0", rdata);
    end
    @(negedge clk);
    we0 = 0; re = 2'b11;
  endtask

  task automatic test_clear();
    int nbusy, ndone, done_c, zbad;
    nbusy = 0; ndone = 0; done_c = 0; zbad = 0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we0 = 1; waddr0 = 5'(i); wdata0 = 32'(i);
    end
    @(negedge clk);
    we0 = 0; re = 2'b11; raddr = {5'd31, 5'd9};
    #1;
    vecs++;
    if (rdata !== {32'd31, 32'd9}) begin
      errs++; $display("FAIL clr_preload got=%h exp=%h", rdata, {32'd31, 32'd9});
    end
    clr_req = 1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1)  clr_req = 0;
      if (c == 20) begin we0 = 1; waddr0 = 5'd9; wdata0 = 32'h5; end
      if (c == 21) we0 = 0;
      #1;
      if (busy) begin
        nbusy++;
        if (rdata !== 64'h0) zbad++;
      end
      if (done) begin ndone++; done_c = c; end
    end
    vecs++;
    if (nbusy != 31) begin
      errs++; $display("FAIL clr_busy_len got=%0d exp=31", nbusy);
    end
    vecs++;
    if (ndone != 1 || done_c != 31) begin
      errs++; $display("FAIL clr_done got=%0d pulses at %0d exp=1 at 31", ndone, done_c);
    end
    vecs++;
    if (zbad != 0) begin
      errs++; $display("FAIL clr_rdata_busy got=%0d nonzero exp=0", zbad);
    end
    for (int a = 1; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      vecs++;
      if (rdata !== 64'h0) begin
        errs++; $display("FAIL clr_after addr=%0d got=%h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int ndone;
    ndone = 0;
    @(negedge clk);
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'h44;
    @(negedge clk);
    waddr0 = 5'd31; wdata0 = 32'h3131;
    @(negedge clk);
    we0 = 0; clr_req = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) clr_req = 0;
    end
    #1;
    vecs++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL rmc_busy_pre got=%b exp=1", busy);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || rdata !== 64'h0) begin
      errs++; $display("FAIL rmc_async busy=%b done=%b rdata=%h exp=0/0/0", busy, done, rdata);
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 3) rst = 1'b1;
      #1;
      if (done) ndone++;
    end
    vecs++;
    if (ndone != 0 || busy !== 1'b0) begin
      errs++; $display("FAIL rmc_no_done pulses=%0d busy=%b exp=0/0", ndone, busy);
    end
    raddr = {5'd31, 5'd4};
    #1;
    vecs++;
    if (rdata !== 64'h0) begin
      errs++; $display("FAIL rmc_entries got=%h exp=0", rdata);
    end
    @(negedge clk);
    we0 = 1; waddr0 = 5'd2; wdata0 = 32'hABCD;
    @(negedge clk);
    we0 = 0; raddr = {5'd0, 5'd2};
    #1;
    vecs++;
    if (rdata[31:0] !== 32'hABCD) begin
      errs++; $display("FAIL rmc_write got=%h exp=abcd", rdata[31:0]);
    end
  endtask

  task automatic test_sweep();
    int nbusy, ndone, done_c;
    nbusy = 0; ndone = 0; done_c = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      we0_b = 1; waddr0_b = 3'(i); wdata0_b = 16'(i * 16'h1111);
    end
    @(negedge clk);
    we0_b = 0; re_b = 4'hf; raddr_b = {3'd7, 3'd5, 3'd3, 3'd1};
    #1;
    vecs++;
    if (rdata_b[15:0] !== 16'h1111) begin
      errs++; $display("FAIL sw_p0 got=%h exp=1111", rdata_b[15:0]);
    end
    vecs++;
    if (rdata_b[31:16] !== 16'h3333) begin
      errs++; $display("FAIL sw_p1 got=%h exp=3333", rdata_b[31:16]);
    end
    vecs++;
    if (rdata_b[47:32] !== 16'h5555) begin
      errs++; $display("FAIL sw_p2 got=%h exp=5555", rdata_b[47:32]);
    end
    vecs++;
    if (rdata_b[63:48] !== 16'h7777) begin
      errs++; $display("FAIL sw_p3 got=%h exp=7777", rdata_b[63:48]);
    end
    clr_req_b = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) clr_req_b = 0;
      #1;
      if (busy_b) nbusy++;
      if (done_b) begin ndone++; done_c = c; end
    end
    vecs++;
    if (nbusy != 7 || ndone != 1 || done_c != 7) begin
      errs++; $display("FAIL sw_clear busy=%0d done=%0d@%0d exp=7 1@7", nbusy, ndone, done_c);
    end
    vecs++;
    if (rdata_b !== 64'h0) begin
      errs++; $display("FAIL sw_after got=%h exp=0", rdata_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
